insn_sequencer: RTL and testbench

//  Upstream stage of the decoder. Latches each opcode byte from the data bus and

---
 rtl/insn_sequencer.sv | 163 ++++++++++++++++
 tb/tb_insn_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insn_sequencer.sv
// Opcode latch and reset/NMI/IRQ arbiter feeding the decoder; injects BRK_OPCODE for hardware events.
// Optional INSN_SEQ_SYNC_EN: 2-flop synchronizers on nmi/irq (+2 cycles request latency).
module insn_sequencer #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter logic [7:0]  BRK_OPCODE   = 8'h00,
  parameter logic [7:0]  IDLE_OPCODE  = 8'hEA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  data_in,
  input  logic        last_cycle,
  input  logic        nmi,
  input  logic        irq,
  input  logic        i_flag,
  output logic        fetch_req,
  output logic [7:0]  insn,
  output logic        insn_valid,
  output logic [1:0]  int_kind,
  output logic        b_flag,
  output logic [15:0] vector
);

  localparam int unsigned CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [1:0]  K_NONE  = 2'd0;
  localparam logic [1:0]  K_RESET = 2'd1;
  localparam logic [1:0]  K_NMI   = 2'd2;
  localparam logic [1:0]  K_IRQ   = 2'd3;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

  typedef enum logic [1:0] {S_RESET, S_FETCH, S_EXEC} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] rst_cnt, rst_cnt_d;
  logic             nmi_s, irq_s;
  logic             nmi_prev, nmi_pend, nmi_accept;
  logic             fetch_req_d, insn_valid_d, b_flag_d;
  logic [7:0]       insn_d;
  logic [1:0]       int_kind_d;
  logic [15:0]      vector_d;

`ifdef INSN_SEQ_SYNC_EN
  logic [1:0] nmi_sync, irq_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_sync <= '0;
      irq_sync <= '0;
    end else begin
      nmi_sync <= {nmi_sync[0], nmi};
      irq_sync <= {irq_sync[0], irq};
    end
  end

  assign nmi_s = nmi_sync[1];
  assign irq_s = irq_sync[1];
`else
  assign nmi_s = nmi;
  assign irq_s = irq;
`endif

  // NMI edge detect ignores rdy; a new edge wins over a same-cycle accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_prev <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      nmi_prev <= nmi_s;
      nmi_pend <= (nmi_s & ~nmi_prev) | (nmi_pend & ~nmi_accept);
    end
  end

  // State and registered outputs; everything freezes while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RESET;
      rst_cnt    <= '0;
      fetch_req  <= 1'b0;
      insn       <= IDLE_OPCODE;
      insn_valid <= 1'b0;
      int_kind   <= K_NONE;
      b_flag     <= 1'b0;
      vector     <= VEC_RESET;
    end else if (rdy) begin
      state      <= state_d;
      rst_cnt    <= rst_cnt_d;
      fetch_req  <= fetch_req_d;
      insn       <= insn_d;
      insn_valid <= insn_valid_d;
      int_kind   <= int_kind_d;
      b_flag     <= b_flag_d;
      vector     <= vector_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_RESET: if (rst_cnt == CNT_W'(RESET_CYCLES - 1)) state_d = S_EXEC;
      S_FETCH: state_d = S_EXEC;
      S_EXEC:  if (last_cycle && !nmi_pend && !(irq_s && !i_flag)) state_d = S_FETCH;
      default: state_d = S_RESET;
    endcase
  end

  // Next output values; hold by default.
  always_comb begin
    rst_cnt_d    = rst_cnt;
    insn_d       = insn;
    insn_valid_d = insn_valid;
    int_kind_d   = int_kind;
    b_flag_d     = b_flag;
    vector_d     = vector;
    nmi_accept   = 1'b0;
    fetch_req_d  = (state_d == S_FETCH);
    case (state)
      S_RESET: begin
        rst_cnt_d = rst_cnt + CNT_W'(1);
        if (rst_cnt == CNT_W'(RESET_CYCLES - 1)) begin
          insn_d       = BRK_OPCODE;
          insn_valid_d = 1'b1;
          int_kind_d   = K_RESET;
          b_flag_d     = 1'b0;
          vector_d     = VEC_RESET;
        end
      end
      S_FETCH: begin
        insn_d       = data_in;
        insn_valid_d = 1'b1;
        int_kind_d   = K_NONE;
        b_flag_d     = (data_in == BRK_OPCODE);
        if (data_in == BRK_OPCODE) vector_d = VEC_IRQ;
      end
      S_EXEC: begin
        if (last_cycle) begin
          if (nmi_pend) begin
            nmi_accept   = rdy;
            insn_d       = BRK_OPCODE;
            insn_valid_d = 1'b1;
            int_kind_d   = K_NMI;
            b_flag_d     = 1'b0;
            vector_d     = VEC_NMI;
          end else if (irq_s && !i_flag) begin
            insn_d       = BRK_OPCODE;
            insn_valid_d = 1'b1;
            int_kind_d   = K_IRQ;
            b_flag_d     = 1'b0;
            vector_d     = VEC_IRQ;
          end else begin
            insn_d       = IDLE_OPCODE;
            insn_valid_d = 1'b0;
            int_kind_d   = K_NONE;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_insn_sequencer.sv
// Self-checking bench for insn_sequencer: directed scenarios plus random traffic vs. a behavioural model.
module tb_insn_sequencer;

  localparam int RESET_CYCLES = 2;
  localparam int PH_RESET = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_EXEC  = 2;

  logic        clk, rst, rdy, last_cycle, nmi, irq, i_flag;
  logic [7:0]  data_in;
  logic        fetch_req, insn_valid, b_flag;
  logic [7:0]  insn;
  logic [1:0]  int_kind;
  logic [15:0] vector;
  logic [28:0] obs;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int          m_phase, m_cnt;
  logic        m_pend, m_prev;
  logic [1:0]  m_nsync, m_isync;
  logic        m_fetch, m_valid, m_b;
  logic [7:0]  m_insn;
  logic [1:0]  m_kind;
  logic [15:0] m_vec;

  insn_sequencer #(.RESET_CYCLES(RESET_CYCLES)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .data_in(data_in), .last_cycle(last_cycle),
    .nmi(nmi), .irq(irq), .i_flag(i_flag), .fetch_req(fetch_req), .insn(insn),
    .insn_valid(insn_valid), .int_kind(int_kind), .b_flag(b_flag), .vector(vector)
  );

  assign obs = {fetch_req, insn, insn_valid, int_kind, b_flag, vector};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [28:0] model_vec();
    return {m_fetch, m_insn, m_valid, m_kind, m_b, m_vec};
  endfunction

  task automatic model_inject(input logic [1:0] kind, input logic [15:0] vec);
    m_insn  = 8'h00;
    m_valid = 1'b1;
    m_kind  = kind;
    m_b     = 1'b0;
    m_vec   = vec;
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic n_e, i_e, set_e, clr;
`ifdef INSN_SEQ_SYNC_EN
    n_e = m_nsync[1];
    i_e = m_isync[1];
`else
    n_e = nmi;
    i_e = irq;
`endif
    if (rst) begin
      m_phase = PH_RESET; m_cnt = 0; m_pend = 1'b0; m_prev = 1'b0;
      m_nsync = 2'b00; m_isync = 2'b00;
      m_fetch = 1'b0; m_insn = 8'hEA; m_valid = 1'b0; m_kind = 2'd0;
      m_b = 1'b0; m_vec = 16'hFFFC;
      return;
    end
    m_nsync = {m_nsync[0], nmi};
    m_isync = {m_isync[0], irq};
    set_e  = n_e && !m_prev;
    m_prev = n_e;
    clr    = 1'b0;
    if (rdy) begin
      if (m_phase == PH_RESET) begin
        if (m_cnt == RESET_CYCLES - 1) begin
          model_inject(2'd1, 16'hFFFC);
          m_phase = PH_EXEC;
        end
        m_cnt++;
      end else if (m_phase == PH_FETCH) begin
        m_insn = data_in; m_valid = 1'b1; m_kind = 2'd0;
        m_b = (data_in == 8'h00);
        if (data_in == 8'h00) m_vec = 16'hFFFE;
        m_phase = PH_EXEC;
      end else if (last_cycle) begin
        if (m_pend) begin
          model_inject(2'd2, 16'hFFFA);
          clr = 1'b1;
        end else if (i_e && !i_flag) begin
          model_inject(2'd3, 16'hFFFE);
        end else begin
          m_insn = 8'hEA; m_valid = 1'b0; m_kind = 2'd0;
          m_phase = PH_FETCH;
        end
      end
      m_fetch = (m_phase == PH_FETCH);
    end
    m_pend = set_e || (m_pend && !clr);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (obs !== {1'b0, 8'hEA, 1'b0, 2'd0, 1'b0, 16'hFFFC}) begin
      bad++; $display("FAIL reset_values got=%h want=%h", obs, {1'b0, 8'hEA, 1'b0, 2'd0, 1'b0, 16'hFFFC});
    end
    rst = 1'b0;
    tick();
    total++;
    if (insn_valid !== 1'b0) begin
      bad++; $display("FAIL reset_hold insn_valid got=%b want=0", insn_valid);
    end
    tick();
    total++;
    if (obs !== {1'b0, 8'h00, 1'b1, 2'd1, 1'b0, 16'hFFFC}) begin
      bad++; $display("FAIL reset_inject got=%h want=%h", obs, {1'b0, 8'h00, 1'b1, 2'd1, 1'b0, 16'hFFFC});
    end
  endtask

  task automatic test_fetch();
    last_cycle = 1'b1;
    tick();
    total++;
    if (obs !== {1'b1, 8'hEA, 1'b0, 2'd0, 1'b0, 16'hFFFC}) begin
      bad++; $display("FAIL fetch_enter got=%h want=%h", obs, {1'b1, 8'hEA, 1'b0, 2'd0, 1'b0, 16'hFFFC});
    end
    last_cycle = 1'b0; data_in = 8'hA9;
    tick();
    total++;
    if (obs !== {1'b0, 8'hA9, 1'b1, 2'd0, 1'b0, 16'hFFFC}) begin
      bad++; $display("FAIL fetch_latch got=%h want=%h", obs, {1'b0, 8'hA9, 1'b1, 2'd0, 1'b0, 16'hFFFC});
    end
    last_cycle = 1'b1;
    tick();
    total++;
    if (obs !== {1'b1, 8'hEA, 1'b0, 2'd0, 1'b0, 16'hFFFC}) begin
      bad++; $display("FAIL fetch_boundary got=%h want=%h", obs, {1'b1, 8'hEA, 1'b0, 2'd0, 1'b0, 16'hFFFC});
    end
  endtask

  // Rows: {nmi, irq, i_flag, last_cycle, data_in}
  task automatic test_nmi_irq();
    logic [11:0] rows [7];
    rows = '{{4'b0000, 8'h20}, {4'b1000, 8'h20}, {4'b1000, 8'h20}, {4'b1000, 8'h20},
             {4'b1101, 8'h20}, {4'b1101, 8'h20}, {4'b0001, 8'h20}};
    for (int i = 0; i < 7; i++) begin
      {nmi, irq, i_flag, last_cycle} = rows[i][11:8];
      data_in = rows[i][7:0];
      tick();
      total++;
      if (obs !== model_vec()) begin
        bad++; $display("FAIL nmi_irq step=%0d got=%h want=%h", i, obs, model_vec());
      end
    end
    total++;
    if (fetch_req !== 1'b1) begin
      bad++; $display("FAIL nmi_irq_done fetch_req got=%b want=1", fetch_req);
    end
  endtask

  task automatic test_irq_masked();
    logic [11:0] rows [4];
    rows = '{{4'b0000, 8'h18}, {4'b0111, 8'h18}, {4'b0100, 8'h00}, {4'b0000, 8'h00}};
    for (int i = 0; i < 4; i++) begin
      {nmi, irq, i_flag, last_cycle} = rows[i][11:8];
      data_in = rows[i][7:0];
      tick();
      total++;
      if (obs !== model_vec()) begin
        bad++; $display("FAIL irq_masked step=%0d got=%h want=%h", i, obs, model_vec());
      end
    end
    total++;
    if ({b_flag, vector, int_kind} !== {1'b1, 16'hFFFE, 2'd0}) begin
      bad++; $display("FAIL soft_brk got=%h want=%h", {b_flag, vector, int_kind}, {1'b1, 16'hFFFE, 2'd0});
    end
  endtask

  task automatic test_rdy_stall();
    logic [28:0] snap;
    irq = 1'b0; i_flag = 1'b0;
    snap = obs;
    rdy = 1'b0; last_cycle = 1'b1; data_in = 8'h55;
    for (int i = 0; i < 5; i++) begin
      nmi = (i >= 1);
      tick();
      total++;
      if (obs !== snap) begin
        bad++; $display("FAIL stall_frozen step=%0d got=%h want=%h", i, obs, snap);
      end
    end
    rdy = 1'b1;
    tick();
    total++;
    if (obs !== model_vec() || int_kind !== 2'd2) begin
      bad++; $display("FAIL stall_nmi got=%h want=%h", obs, model_vec());
    end
    tick();
    total++;
    if (obs !== model_vec() || insn_valid !== 1'b0) begin
      bad++; $display("FAIL stall_no_retrigger got=%h want=%h", obs, model_vec());
    end
  endtask

  task automatic test_reset_abort();
    nmi = 1'b0; last_cycle = 1'b0; data_in = 8'hEA;
    for (int i = 0; i < 4; i++) tick();
    nmi = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    last_cycle = 1'b1;
    tick();
    total++;
    if (obs !== model_vec()) begin
      bad++; $display("FAIL abort_nmi got=%h want=%h", obs, model_vec());
    end
    last_cycle = 1'b0; nmi = 1'b0;
    tick();
    nmi = 1'b1;
    tick();
    rst = 1'b1; nmi = 1'b0;
    tick();
    total++;
    if (obs !== {1'b0, 8'hEA, 1'b0, 2'd0, 1'b0, 16'hFFFC}) begin
      bad++; $display("FAIL abort_reset got=%h want=%h", obs, {1'b0, 8'hEA, 1'b0, 2'd0, 1'b0, 16'hFFFC});
    end
    rst = 1'b0;
    for (int i = 0; i < RESET_CYCLES; i++) tick();
    last_cycle = 1'b1;
    tick();
    total++;
    if (obs !== model_vec() || {fetch_req, insn_valid} !== 2'b10) begin
      bad++; $display("FAIL abort_pend_cleared got=%h want=%h", obs, model_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom % 70) == 0;
      rdy        = ($urandom % 5) != 0;
      last_cycle = ($urandom % 3) == 0;
      if (($urandom % 6) == 0) nmi = ~nmi;
      irq        = ($urandom % 4) == 0;
      i_flag     = ($urandom % 2) == 0;
      data_in    = (($urandom % 4) == 0) ? 8'h00 : 8'($urandom);
      tick();
      total++;
      if (obs !== model_vec()) begin
        bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, model_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; data_in = 8'h00; last_cycle = 1'b0;
    nmi = 1'b0; irq = 1'b0; i_flag = 1'b0;
    m_phase = PH_RESET; m_cnt = 0; m_pend = 1'b0; m_prev = 1'b0;
    m_nsync = 2'b00; m_isync = 2'b00;
    m_fetch = 1'b0; m_insn = 8'hEA; m_valid = 1'b0; m_kind = 2'd0;
    m_b = 1'b0; m_vec = 16'hFFFC;
    #1;
    test_reset();
    test_fetch();
    test_nmi_irq();
    test_irq_masked();
    test_rdy_stall();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
